// File: rtl/seg_rw_mp.sv
// Multi-channel segment read/write memory: round-robin arbitration across NCH request streams,
// out-of-range error responses, and a one-entry-per-cycle bulk-clear sweep.
module seg_rw_mp #(
  parameter int unsigned NELEMS = 127,
  parameter int unsigned AW     = 7,
  parameter int unsigned DW     = 7,
  parameter int unsigned NCH    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH-1:0]    req_write,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    rsp_valid,
  input  logic [NCH-1:0]    rsp_ready,
  output logic [NCH*DW-1:0] rsp_data,
  output logic [NCH-1:0]    rsp_err,
  input  logic              clear_start,
  output logic              busy
);
  localparam int unsigned   PW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [0:0]    RUN     = 1'b0;
  localparam logic [0:0]    CLEAR   = 1'b1;
  localparam logic [AW:0]   LIMIT   = (AW + 1)'(NELEMS);
  localparam logic [AW-1:0] LAST    = AW'(NELEMS - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(NCH - 1);

  logic [DW-1:0]          mem [NELEMS];
  logic [0:0]             state_q;
  logic [AW-1:0]          clr_cnt_q;
  logic [PW-1:0]          rr_ptr_q;
  logic [NCH-1:0]         rsp_valid_q;
  logic [NCH-1:0]         rsp_err_q;
  logic [NCH-1:0][DW-1:0] rsp_data_q;

  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant;
  logic [PW-1:0]  gnt_idx;
  logic [PW-1:0]  scan_idx;
  logic           gnt_any;
  logic [AW-1:0]  gnt_addr;
  logic [DW-1:0]  gnt_data;
  logic [DW-1:0]  rd_data;
  logic           gnt_write;
  logic           in_range;

  // A channel may take a new request only if its response slot frees up this cycle.
  assign eligible = req_valid & (~rsp_valid_q | rsp_ready);

  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    if (reset && (state_q == RUN) && !clear_start) begin
      for (int k = 0; k < int'(NCH); k++) begin
        scan_idx = PW'((32'(rr_ptr_q) + 32'(k)) % NCH);
        if (!gnt_any && eligible[scan_idx]) begin
          gnt_any         = 1'b1;
          grant[scan_idx] = 1'b1;
          gnt_idx         = scan_idx;
        end
      end
    end
  end

  assign gnt_addr  = req_addr[gnt_idx*AW +: AW];
  assign gnt_data  = req_data[gnt_idx*DW +: DW];
  assign gnt_write = req_write[gnt_idx];
  assign in_range  = {1'b0, gnt_addr} < LIMIT;
  assign rd_data   = in_range ? mem[gnt_addr] : '0;

  // Storage has no reset; a sweep interrupted by reset leaves it partially cleared.
  always_ff @(posedge clock) begin
    if (state_q == CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (gnt_any && gnt_write && in_range) begin
      mem[gnt_addr] <= gnt_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      clr_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (state_q == RUN) begin
        if (clear_start) begin
          state_q   <= CLEAR;
          clr_cnt_q <= '0;
        end
      end else if (clr_cnt_q == LAST) begin
        state_q   <= RUN;
        clr_cnt_q <= '0;
      end else begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end

      if (gnt_any) begin
        rr_ptr_q <= (gnt_idx == PTR_MAX) ? '0 : gnt_idx + 1'b1;
      end

      for (int i = 0; i < int'(NCH); i++) begin
        if (grant[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_err_q[i]   <= !in_range;
          rsp_data_q[i]  <= (!gnt_write && in_range) ? rd_data : '0;
        end else if (rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
          rsp_err_q[i]   <= 1'b0;
          rsp_data_q[i]  <= '0;
        end
      end
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q == CLEAR);

endmodule
